// File: rtl/bus_pkg.sv
// bus_pkg: constants shared by the CPU-bus slave blocks.
//   - register offsets within the 8-byte window decoded from AB[2:0]
//   - CTRL and STAT bit positions
//   - default base address of the timer window
package bus_pkg;

  localparam logic [15:0] BUS_BASE_DEFAULT = 16'hFE00;

  localparam logic [2:0] REG_CNT_L = 3'd0;
  localparam logic [2:0] REG_CNT_H = 3'd1;
  localparam logic [2:0] REG_RLD_L = 3'd2;
  localparam logic [2:0] REG_RLD_H = 3'd3;
  localparam logic [2:0] REG_CTRL  = 3'd4;
  localparam logic [2:0] REG_STAT  = 3'd5;
  localparam logic [2:0] REG_PRE   = 3'd6;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_ONESHOT  = 1;
  localparam int CTRL_TIRQ_EN  = 2;
  localparam int CTRL_EIRQ_EN  = 3;
  localparam int CTRL_EDGE_POL = 4;

  localparam int STAT_TFLAG = 0;
  localparam int STAT_EFLAG = 1;
  localparam int STAT_IRQ   = 7;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: brings an asynchronous line into the clk domain and emits a
// one-cycle pulse on the selected edge.
// Ports:
//   clk        - clock
//   reset_n    - asynchronous active-low reset
//   async_in   - asynchronous input line
//   rising_sel - 1 = detect rising edges, 0 = detect falling edges
//   pulse      - one-cycle pulse, valid while the synchronised level differs
//                from the previous synchronised level in the chosen direction
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  input  logic rising_sel,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= async_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign pulse = rising_sel ? (sync2_reg & ~prev_reg) : (~sync2_reg & prev_reg);

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped timer / interrupt responder on the CPU bus.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   AB, DO, WE   - CPU address, write data, write strobe
//   DI, hit      - registered read data and "DI is ours" flag (one-cycle latency)
//   ext_irq      - asynchronous external interrupt line
//   irq          - registered level interrupt request to the core
module bus_timer
  import bus_pkg::*;
#(
  parameter logic [15:0] BASE = BUS_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        hit,
  input  logic        ext_irq,
  output logic        irq
);

  logic [4:0]  ctrl_reg, ctrl_next;
  logic        tflag_reg, tflag_next;
  logic        eflag_reg, eflag_next;
  logic [7:0]  pre_reg, rld_l_reg, shadow_reg, pcnt_reg;
  logic [15:0] reload_reg, counter_reg;
  logic        irq_reg;
  logic [7:0]  rdata_next;

  logic       sel, rd_en, wr_en;
  logic [2:0] off;
  logic       tick, expire, ext_pulse;

  assign off   = AB[2:0];
  assign sel   = (AB[15:3] == BASE[15:3]);
  assign rd_en = sel & ~WE;
  assign wr_en = sel & WE;

  assign tick   = ctrl_reg[CTRL_RUN] && (pcnt_reg == 8'd0);
  assign expire = tick && (counter_reg == 16'd0);

  edge_sync u_ext (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (ext_irq),
    .rising_sel(ctrl_reg[CTRL_EDGE_POL]),
    .pulse     (ext_pulse)
  );

  // Control and flags: hardware set beats a same-cycle W1C; a one-shot
  // expiry clears run after any same-cycle CTRL write has been applied.
  always_comb begin
    ctrl_next  = ctrl_reg;
    tflag_next = tflag_reg;
    eflag_next = eflag_reg;
    if (wr_en && off == REG_CTRL) ctrl_next = DO[4:0];
    if (expire && ctrl_reg[CTRL_ONESHOT]) ctrl_next[CTRL_RUN] = 1'b0;
    if (wr_en && off == REG_STAT && DO[STAT_TFLAG]) tflag_next = 1'b0;
    if (wr_en && off == REG_STAT && DO[STAT_EFLAG]) eflag_next = 1'b0;
    if (expire) tflag_next = 1'b1;
    if (ext_pulse) eflag_next = 1'b1;
  end

  always_comb begin
    rdata_next = 8'h00;
    case (off)
      REG_CNT_L: rdata_next = counter_reg[7:0];
      REG_CNT_H: rdata_next = shadow_reg;
      REG_CTRL:  rdata_next = {3'b000, ctrl_reg};
      REG_STAT: begin
        rdata_next[STAT_TFLAG] = tflag_reg;
        rdata_next[STAT_EFLAG] = eflag_reg;
        rdata_next[STAT_IRQ]   = irq_reg;
      end
      REG_PRE:   rdata_next = pre_reg;
      default:   rdata_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg    <= '0;
      tflag_reg   <= 1'b0;
      eflag_reg   <= 1'b0;
      pre_reg     <= '0;
      rld_l_reg   <= '0;
      shadow_reg  <= '0;
      pcnt_reg    <= '0;
      reload_reg  <= '0;
      counter_reg <= '0;
      irq_reg     <= 1'b0;
      DI          <= '0;
      hit         <= 1'b0;
    end else begin
      ctrl_reg  <= ctrl_next;
      tflag_reg <= tflag_next;
      eflag_reg <= eflag_next;
      irq_reg   <= (tflag_reg & ctrl_reg[CTRL_TIRQ_EN]) | (eflag_reg & ctrl_reg[CTRL_EIRQ_EN]);

      if (wr_en && off == REG_PRE)   pre_reg   <= DO;
      if (wr_en && off == REG_RLD_L) rld_l_reg <= DO;

      // Prescaler parks at PRE while stopped so a fresh start divides by PRE+1.
      if (!ctrl_reg[CTRL_RUN] || pcnt_reg == 8'd0) pcnt_reg <= pre_reg;
      else                                         pcnt_reg <= pcnt_reg - 8'd1;

      // An RLD_H write overrides whatever the tick would have done to the counter.
      if (wr_en && off == REG_RLD_H) begin
        reload_reg  <= {DO, rld_l_reg};
        counter_reg <= {DO, rld_l_reg};
      end else if (tick) begin
        if (counter_reg != 16'd0)           counter_reg <= counter_reg - 16'd1;
        else if (!ctrl_reg[CTRL_ONESHOT])   counter_reg <= reload_reg;
      end

      // Reading the low byte freezes the high byte for a coherent 16-bit read.
      if (rd_en && off == REG_CNT_L) shadow_reg <= counter_reg[15:8];

      hit <= rd_en;
      DI  <= rd_en ? rdata_next : 8'h00;
    end
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_bus_timer.sv
module tb_bus_timer;

  localparam logic [15:0] B = 16'hFE00;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] AB = 16'h0000;
  logic [7:0]  DO = 8'h00;
  logic        WE = 1'b0;
  logic [7:0]  DI;
  logic        hit;
  logic        ext_irq = 1'b1;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bus_timer dut (
    .clk    (clk),
    .reset_n(reset_n),
    .AB     (AB),
    .DO     (DO),
    .WE     (WE),
    .DI     (DI),
    .hit    (hit),
    .ext_irq(ext_irq),
    .irq    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---- bus helpers: each takes exactly one clock, starting just after an edge
  task automatic wr(input logic [2:0] o, input logic [7:0] d);
    AB = B | {13'd0, o}; DO = d; WE = 1'b1;
    @(posedge clk); #1;
    WE = 1'b0; AB = 16'h0000; DO = 8'h00;
    $display("WR  off=%0d data=%02h", o, d);
  endtask

  task automatic rd(input logic [2:0] o, output logic [7:0] d, output logic h);
    AB = B | {13'd0, o}; WE = 1'b0;
    @(posedge clk); #1;
    d = DI; h = hit; AB = 16'h0000;
    $display("RD  off=%0d data=%02h hit=%0b irq=%0b", o, d, h, irq);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    AB = 16'h0000; WE = 1'b0; DO = 8'h00;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic wait_irq(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin t = cyc; break; end
    end
  endtask

  // ---- tests
  task automatic test_reset;
    logic [7:0] d; logic h;
    do_reset;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %0b expected 0", irq); end
    for (int o = 0; o < 8; o++) begin
      rd(3'(o), d, h);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL reset_di off=%0d: got %02h expected 00", o, d); end
      checks++;
      if (h !== 1'b1) begin failures++; $display("FAIL reset_hit off=%0d: got %0b expected 1", o, h); end
    end
    wr(3'd7, 8'hAA);
    checks++;
    if (hit !== 1'b0) begin failures++; $display("FAIL write_no_hit: got %0b expected 0", hit); end
    rd(3'd7, d, h);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL off7_read: got %02h expected 00", d); end
    wr(3'd2, 8'h55);
    rd(3'd2, d, h);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL rld_l_read: got %02h expected 00", d); end
    wr(3'd6, 8'h3C);
    rd(3'd6, d, h);
    checks++;
    if (d !== 8'h3C) begin failures++; $display("FAIL pre_readback: got %02h expected 3c", d); end
    // Address just below the window must not respond.
    AB = 16'hFDFE; WE = 1'b0;
    @(posedge clk); #1;
    AB = 16'h0000;
    checks++;
    if (hit !== 1'b0 || DI !== 8'h00) begin
      failures++; $display("FAIL miss_read: got hit=%0b di=%02h expected hit=0 di=00", hit, DI);
    end
  endtask

  task automatic test_periodic;
    logic [7:0] d; logic h; int c0, t1, t2;
    do_reset;
    wr(3'd6, 8'd1); wr(3'd2, 8'd4); wr(3'd3, 8'd0); wr(3'd4, 8'h05);
    c0 = cyc;
    wait_irq(100, t1);
    checks++;
    if (t1 != c0 + 11) begin failures++; $display("FAIL periodic_first: got cycle %0d expected %0d", t1 - c0, 11); end
    rd(3'd5, d, h);
    checks++;
    if (d !== 8'h81) begin failures++; $display("FAIL periodic_stat: got %02h expected 81", d); end
    wr(3'd5, 8'h01);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL periodic_w1c_lat: got %0b expected 1", irq); end
    idle(1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL periodic_w1c_drop: got %0b expected 0", irq); end
    wait_irq(100, t2);
    checks++;
    if (t2 - t1 != 10) begin failures++; $display("FAIL periodic_period: got %0d expected 10", t2 - t1); end
  endtask

  task automatic test_oneshot;
    logic [7:0] d; logic h; int c0, t;
    do_reset;
    wr(3'd6, 8'd0); wr(3'd2, 8'd2); wr(3'd3, 8'd0); wr(3'd4, 8'h07);
    c0 = cyc;
    wait_irq(50, t);
    checks++;
    if (t != c0 + 4) begin failures++; $display("FAIL oneshot_irq: got cycle %0d expected 4", t - c0); end
    rd(3'd4, d, h);
    checks++;
    if (d !== 8'h06) begin failures++; $display("FAIL oneshot_ctrl: got %02h expected 06", d); end
    idle(5);
    rd(3'd0, d, h);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL oneshot_cnt_l: got %02h expected 00", d); end
    rd(3'd1, d, h);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL oneshot_cnt_h: got %02h expected 00", d); end
  endtask

  task automatic test_coherent;
    logic [7:0] d; logic h;
    do_reset;
    wr(3'd6, 8'd0); wr(3'd4, 8'h01); wr(3'd2, 8'h00); wr(3'd3, 8'h01);
    rd(3'd0, d, h);                       // counter = 0x0100 here
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL coherent_lo: got %02h expected 00", d); end
    idle(4);
    rd(3'd1, d, h);                       // five cycles later
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL coherent_hi: got %02h expected 01", d); end
    rd(3'd0, d, h);                       // 6 ticks after 0x0100
    checks++;
    if (d !== 8'hFA) begin failures++; $display("FAIL coherent_lo2: got %02h expected fa", d); end
    rd(3'd1, d, h);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL coherent_hi2: got %02h expected 00", d); end
  endtask

  task automatic test_ext;
    logic [7:0] d; logic h;
    logic [7:0] exp_stat [5];
    logic       exp_irq  [5];
    exp_stat = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h82};
    exp_irq  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ext_irq = 1'b1;
    do_reset;
    idle(4);
    wr(3'd4, 8'h08);
    ext_irq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rd(3'd5, d, h);
      checks++;
      if (d !== exp_stat[k]) begin failures++; $display("FAIL ext_stat k=%0d: got %02h expected %02h", k, d, exp_stat[k]); end
      checks++;
      if (irq !== exp_irq[k]) begin failures++; $display("FAIL ext_irq k=%0d: got %0b expected %0b", k, irq, exp_irq[k]); end
    end
    wr(3'd5, 8'h02);
    idle(2);
    ext_irq = 1'b1;
    idle(6);
    rd(3'd5, d, h);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL ext_rising_ignored: got %02h expected 00", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL ext_rising_irq: got %0b expected 0", irq); end
  endtask

  task automatic test_collisions;
    logic [7:0] d; logic h; int r; logic [15:0] v;
    // W1C landing on the same edge as the second expiry
    r = $urandom_range(2, 6);
    do_reset;
    wr(3'd6, 8'd0); wr(3'd2, 8'(r)); wr(3'd3, 8'd0); wr(3'd4, 8'h01);
    idle(2 * r + 1);
    wr(3'd5, 8'h01);
    rd(3'd5, d, h);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL w1c_collision r=%0d: got %02h expected 01", r, d); end
    wr(3'd5, 8'h01);
    rd(3'd5, d, h);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL w1c_plain r=%0d: got %02h expected 00", r, d); end
    // RLD_H write on a tick with counter==0: write wins, flag still set
    v = 16'($urandom_range(16'h0200, 16'hFFFF));
    do_reset;
    wr(3'd6, 8'd0); wr(3'd2, v[7:0]); wr(3'd4, 8'h01);
    wr(3'd3, v[15:8]);
    rd(3'd0, d, h);
    checks++;
    if (d !== v[7:0]) begin failures++; $display("FAIL rld_tick_lo: got %02h expected %02h", d, v[7:0]); end
    rd(3'd1, d, h);
    checks++;
    if (d !== v[15:8]) begin failures++; $display("FAIL rld_tick_hi: got %02h expected %02h", d, v[15:8]); end
    rd(3'd5, d, h);
    checks++;
    if (d[0] !== 1'b1) begin failures++; $display("FAIL rld_tick_flag: got %0b expected 1", d[0]); end
    // RLD_H write on a tick with counter!=0: decrement lost
    v = 16'($urandom_range(16'h0100, 16'hFFFF));
    wr(3'd2, v[7:0]); wr(3'd3, v[15:8]);
    rd(3'd0, d, h);
    checks++;
    if (d !== v[7:0]) begin failures++; $display("FAIL rld_tick_nz: got %02h expected %02h", d, v[7:0]); end
  endtask

  task automatic test_random_period;
    int p, r, c0, t1, t2, per;
    for (int it = 0; it < 3; it++) begin
      p = $urandom_range(0, 3);
      r = $urandom_range(2, 8);
      per = (r + 1) * (p + 1);
      do_reset;
      wr(3'd6, 8'(p)); wr(3'd2, 8'(r)); wr(3'd3, 8'd0); wr(3'd4, 8'h05);
      c0 = cyc;
      wait_irq(200, t1);
      checks++;
      if (t1 != c0 + per + 1) begin failures++; $display("FAIL rand_first p=%0d r=%0d: got %0d expected %0d", p, r, t1 - c0, per + 1); end
      wr(3'd5, 8'h01);
      idle(1);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL rand_clear p=%0d r=%0d: got %0b expected 0", p, r, irq); end
      wait_irq(200, t2);
      checks++;
      if (t2 - t1 != per) begin failures++; $display("FAIL rand_period p=%0d r=%0d: got %0d expected %0d", p, r, t2 - t1, per); end
    end
  endtask

  task automatic test_midreset;
    logic [7:0] d; logic h;
    do_reset;
    wr(3'd6, 8'd0); wr(3'd2, 8'd1); wr(3'd3, 8'd0); wr(3'd4, 8'h05);
    idle(4);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL midreset_pre: got %0b expected 1", irq); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL midreset_async: got %0b expected 0", irq); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(5);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL midreset_idle: got %0b expected 0", irq); end
    rd(3'd4, d, h);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL midreset_ctrl: got %02h expected 00", d); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_periodic;
    test_oneshot;
    test_coherent;
    test_ext;
    test_collisions;
    test_random_period;
    test_midreset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
